muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Successor to the fixed 32-bit multu-only multiplier path.
- Adds signed/unsigned multiply and divide, mthi/mtlo, a busy/done handshake for EX-stage stalling, a cancel for pipeline flush, and divide-by-zero flagging.
- Sits beside the EX-stage ALU. mfhi/mflo read hi_out/lo_out directly.

---
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.
// Multiply is shift-add and divide is restoring; both run on magnitudes, with the sign applied in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Handshake: start is taken only while busy=0. A mul/div raises busy for
    // WIDTH+1 cycles. done pulses for one cycle once HI/LO hold the result.
    // cancel aborts an in-flight operation with no write to HI/LO.
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;      // mul: product; div: {remainder, quotient}
    logic [WIDTH-1:0]     opnd;     // mul: multiplicand; div: divisor
    logic                 is_div, sign_p, sign_r, zero_div;

    logic                 accept, div_op, a_neg, b_neg, b_is_zero;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix, hi_res, lo_res;

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;
    assign accept    = (state_q == IDLE) && start && !op[2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cancel) state_d = IDLE;
                     else if (cnt == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_op    = op[1];
        a_neg     = op[0] && src_a[WIDTH-1];
        b_neg     = op[0] && src_b[WIDTH-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;
        b_is_zero = (src_b == '0);

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

        // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fix  = sign_p ? -acc : acc;
        quo_fix   = sign_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hi_res    = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_res    = is_div ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            sign_p   <= 1'b0;
            sign_r   <= 1'b0;
            zero_div <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // Divide by zero runs on the raw dividend with no sign fix-up,
                        // so HI comes out as src_a and LO as all ones.
                        if (div_op) begin
                            acc  <= {{WIDTH{1'b0}}, (b_is_zero ? src_a : a_mag)};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end
                        is_div   <= div_op;
                        sign_p   <= (a_neg ^ b_neg) && !(div_op && b_is_zero);
                        sign_r   <= a_neg && !(div_op && b_is_zero);
                        zero_div <= div_op && b_is_zero;
                        cnt      <= CNT_W'(WIDTH);
                        div_zero <= 1'b0;
                    end else if (start && op == 3'b100) begin
                        hi_out <= src_a;
                    end else if (start && op == 3'b101) begin
                        lo_out <= src_a;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        cnt <= '0;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= (cnt != '0) ? cnt - 1'b1 : '0;
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        hi_out   <= hi_res;
                        lo_out   <= lo_res;
                        done     <= 1'b1;
                        div_zero <= zero_div;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: a driver pushes reference results,
// and a monitor pops and compares them on every done pulse.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*W:0] exp_q[$];            // {div_zero, hi, lo}
  logic [W-1:0] model_hi, model_lo;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: architectural result from plain arithmetic
  function automatic logic [2*W:0] ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ref_op = '0;
    case (o)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; ref_op = {1'b0, p}; end
      3'd1: begin p = 64'(sa * sb); ref_op = {1'b0, p}; end
      3'd2: begin
        if (b == 0) ref_op = {1'b1, a, 32'hFFFF_FFFF};
        else        ref_op = {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) ref_op = {1'b1, a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = {1'b0, 32'd0, 32'h8000_0000};
        else ref_op = {1'b0, 32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        check("result_hi", 64'(hi_out), 64'(e[2*W-1:W]));
        check("result_lo", 64'(lo_out), 64'(e[W-1:0]));
        check("result_div_zero", 64'(div_zero), 64'(e[2*W]));
      end
    end
  end

  // driver: issue one instruction; mul/div waits for completion
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit with_cancel, input bit poke);
    int cyc;
    logic [2*W:0] e;
    start = 1'b1; op = o; src_a = a; src_b = b; cancel = with_cancel;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    src_a = $urandom; src_b = $urandom;
    if (o < 3'd4) begin
      e = ref_op(o, a, b);
      exp_q.push_back(e);
      @(negedge clk);
      check("busy_after_accept", 64'(busy), 64'd1);
      check("div_zero_cleared", 64'(div_zero), 64'd0);
      cyc = 1;
      while (busy && cyc < 100) begin
        if (poke && cyc == 3) begin
          start = 1'b1; op = 3'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        if (busy) cyc++;
      end
      start = 1'b0;
      check("busy_cycles", 64'(cyc), 64'(W + 1));
      check("done_after_busy", 64'(done), 64'd1);
      model_hi = e[2*W-1:W];
      model_lo = e[W-1:0];
    end else begin
      if (o == 3'd4) model_hi = a;
      if (o == 3'd5) model_lo = a;
      @(negedge clk);
      check("busy_no_muldiv", 64'(busy), 64'd0);
      check("hi_after_move", 64'(hi_out), 64'(model_hi));
      check("lo_after_move", 64'(lo_out), 64'(model_lo));
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0: pick_operand = 32'd0;
      1: pick_operand = 32'hFFFF_FFFF;
      2: pick_operand = 32'h8000_0000;
      3: pick_operand = 32'd1;
      4: pick_operand = 32'($urandom_range(0, 20));
      default: pick_operand = $urandom;
    endcase
  endfunction

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);

    // directed vectors
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("multu_max_hi", 64'(hi_out), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo_out), 64'h0000_0001);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 0, 0);
    check("mult_neg_hi", 64'(hi_out), 64'hFFFF_FFFF);
    check("mult_neg_lo", 64'(lo_out), 64'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("div_neg_lo", 64'(lo_out), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi_out), 64'hFFFF_FFFF);
    run_op(3'd2, 32'd100, 32'd0, 0, 0);
    check("divu_zero_lo", 64'(lo_out), 64'hFFFF_FFFF);
    check("divu_zero_hi", 64'(hi_out), 64'h0000_0064);
    check("divu_zero_flag", 64'(div_zero), 64'd1);
    run_op(3'd0, 32'd3, 32'd5, 0, 0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_ovf_lo", 64'(lo_out), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi_out), 64'd0);
    check("div_ovf_flag", 64'(div_zero), 64'd0);
    run_op(3'd3, 32'hFFFF_FFF0, 32'd0, 0, 0);
    check("div_zero_signed_hi", 64'(hi_out), 64'hFFFF_FFF0);

    // cancel mid-multiply leaves preloaded HI/LO untouched
    run_op(3'd4, 32'h1234, 32'd0, 0, 0);
    run_op(3'd5, 32'h5678, 32'd0, 0, 0);
    start = 1'b1; op = 3'd0; src_a = 32'hDEAD_BEEF; src_b = 32'h1357_9BDF;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("cancel_no_done", 64'(saw_done), 64'd0);
    check("cancel_hi_kept", 64'(hi_out), 64'h1234);
    check("cancel_lo_kept", 64'(lo_out), 64'h5678);

    // cancel in IDLE with a same-cycle start still accepts; start during busy is ignored
    run_op(3'd2, 32'd1000, 32'd7, 1, 0);
    run_op(3'd0, 32'd11, 32'd13, 0, 1);
    run_op(3'd6, 32'hAAAA_5555, 32'd1, 0, 0);
    run_op(3'd7, 32'h5555_AAAA, 32'd1, 0, 0);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a run
    start = 1'b1; op = 3'd1; src_a = 32'h0F0F_0F0F; src_b = 32'hF0F0_F0F0;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_hi", 64'(hi_out), 64'd0);
    check("midrun_reset_lo", 64'(lo_out), 64'd0);
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_done", 64'(done), 64'd0);
    model_hi = '0; model_lo = '0;
    run_op(3'd0, 32'd6, 32'd7, 0, 0);
    check("after_reset_lo", 64'(lo_out), 64'd42);

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
